// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and EX operand forward selects.
// Optional hazard counters (stall_count, flush_count) are compiled in with HAZARD_STATS_EN.

module id_exe_fwd_sel #(
  parameter int REG_W = 5
) (
  input  logic             valid,
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] exe_mem_rd,
  input  logic             exe_mem_reg_write,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic             mem_wb_reg_write,
  output logic [1:0]       sel
);
  // EXE/MEM is checked first so the youngest producer wins; r0 never forwards.
  always_comb begin
    sel = 2'd0;
    if (valid && src != '0) begin
      if (exe_mem_reg_write && exe_mem_rd == src)     sel = 2'd2;
      else if (mem_wb_reg_write && mem_wb_rd == src)  sel = 2'd1;
    end
  end
endmodule

module id_exe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_W-1:0]  exe_mem_rd,
  input  logic              exe_mem_reg_write,
  input  logic [REG_W-1:0]  mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if_id
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);
  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t id_pl, ex_pl;
  logic     load_use;

  assign id_pl = '{rs: id_rs, rt: id_rt, rd: id_rd, rs_data: id_rs_data,
                   rt_data: id_rt_data, imm: id_imm, ctrl: id_ctrl};

  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));

  // A flush kills the dependent instruction anyway, so there is nothing to stall for.
  assign stall_if_id = load_use && !flush && !hold;

  // Payload only loads on a real advance; during a bubble it holds (don't-care while invalid).
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pl        <= '0;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!hold) begin
      if (flush || load_use) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_pl        <= id_pl;
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write && id_valid;
        ex_mem_read  <= id_mem_read && id_valid;
      end
    end
  end

  assign ex_rs      = ex_pl.rs;
  assign ex_rt      = ex_pl.rt;
  assign ex_rd      = ex_pl.rd;
  assign ex_rs_data = ex_pl.rs_data;
  assign ex_rt_data = ex_pl.rt_data;
  assign ex_imm     = ex_pl.imm;
  assign ex_ctrl    = ex_pl.ctrl;

  // One forward selector per EX source operand: [0] = rs, [1] = rt.
  logic [1:0][REG_W-1:0] ex_src;
  logic [1:0][1:0]       fwd;

  assign ex_src = {ex_pl.rt, ex_pl.rs};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_exe_fwd_sel #(.REG_W(REG_W)) u_sel (
      .valid             (ex_valid),
      .src               (ex_src[g]),
      .exe_mem_rd        (exe_mem_rd),
      .exe_mem_reg_write (exe_mem_reg_write),
      .mem_wb_rd         (mem_wb_rd),
      .mem_wb_reg_write  (mem_wb_reg_write),
      .sel               (fwd[g])
    );
  end

  assign forward_a = fwd[0];
  assign forward_b = fwd[1];

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      if (stall_if_id) stall_count <= stall_count + 32'd1;
      if (flush)       flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage 64-bit MIPS pipeline. Sits between decode and the EX-stage operand forwarding muxes.
- Captures decoded operands, immediate, control and register numbers each cycle.
- Detects load-use hazards and inserts a bubble when one occurs.
- Generates the 2-bit forward selects consumed by the EX operand muxes: 0 = ID/EX register value, 1 = WB data, 2 = EXE/MEM result.

Parameters:
- DATA_W, 64, operand/immediate width
- CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through
- REG_W, 5, register-number width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- hold  in  1  global pipeline freeze (e.g. memory wait); all state held
- flush  in  1  branch-taken/exception kill of the ID-stage instruction
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W each  source/dest register numbers
- id_uses_rt  in  1  instruction reads rt as a source
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  control bundle
- id_reg_write, id_mem_read  in  1 each  writes rd / is a load
- exe_mem_rd  in  REG_W  EXE/MEM destination register
- exe_mem_reg_write  in  1  EXE/MEM writes its destination register
- mem_wb_rd  in  REG_W  MEM/WB destination register
- mem_wb_reg_write  in  1  MEM/WB writes its destination register
- ex_valid  out  1  EX stage holds a real instruction
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered register numbers
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands and immediate
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_reg_write, ex_mem_read  out  1 each  registered, gated by valid
- forward_a, forward_b  out  2 each  selects for the rs/rt forwarding muxes
- stall_if_id  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset: all registered outputs are 0 (ex_valid=0, ex_reg_write=0, ex_mem_read=0, data=0, ctrl=0). forward_a/forward_b=0 and stall_if_id=0 follow from these values.
- Combinational load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- stall_if_id = load_use & ~flush & ~hold.
- Update priority at the clock edge, evaluated in order:
  1. rst → reset values.
  2. hold → every register keeps its value.
  3. flush → bubble.
  4. load_use → bubble.
  5. Otherwise → load all id_* fields; ex_valid = id_valid; ex_reg_write = id_reg_write & id_valid; ex_mem_read = id_mem_read & id_valid.
- Bubble: ex_valid, ex_reg_write and ex_mem_read are set to 0. Data, number and ctrl fields may load or hold; they are don't-care when invalid.
- Latency: 1 cycle from ID to EX.
- Load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read. If hold is also asserted, the stall is deferred until hold deasserts.
- forward_a (combinational, from registered ex_rs):
  - 0 if ex_valid=0 or ex_rs=0.
  - Else 2 if exe_mem_reg_write & exe_mem_rd == ex_rs.
  - Else 1 if mem_wb_reg_write & mem_wb_rd == ex_rs.
  - Else 0.
- forward_b: identical rule on ex_rt.
- Code 3 is never produced.
- When EXE/MEM and MEM/WB both match, EXE/MEM wins (youngest result).
- Register 0 never forwards and never causes a stall.
- flush and load_use in the same cycle: flush wins and stall_if_id=0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_count[31:0] and flush_count[31:0], both reset to 0.
  - stall_count increments on each cycle with stall_if_id=1.
  - flush_count increments on each cycle with flush=1 & ~hold.
  - Both wrap modulo 2^32 and are held during hold.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then id_valid=1, id_rs=3, id_rs_data=0x1111, id_reg_write=1 → after 1 clk: ex_valid=1, ex_rs_data=0x1111, ex_reg_write=1, forward_a=0.
- ex_rs=4, exe_mem_rd=4 with exe_mem_reg_write=1, mem_wb_rd=4 with mem_wb_reg_write=1 → forward_a=2. Drop exe_mem_reg_write → forward_a=1. Set ex_rs=0 with all matches → forward_a=0.
- Load in EX (ex_mem_read=1, ex_rd=7); ID has id_rt=7, id_uses_rt=1 → stall_if_id=1 for exactly 1 cycle; next cycle ex_valid=0; the cycle after, the dependent instruction is in EX with forward_b=1 once the load reaches WB.
- Same load-use with id_uses_rt=0 and id_rs≠7 → no stall.
- flush=1 together with load_use=1 → stall_if_id=0; next cycle ex_valid=0 and ex_reg_write=0.
- hold=1 for 3 cycles while id_* fields change → all ex_* outputs stable. With HAZARD_STATS_EN: stall_count and flush_count unchanged during hold; after 2 separate load-use stalls, stall_count=2.
